// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: RISC-V byte/half/word loads and stores on a word-only RAM port.
// Sub-word stores are read-modify-write; bad requests and read timeouts return an error response.
module load_store_unit #(
    parameter logic [1:0] MEM_DISABLE   = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
    parameter logic [1:0] MEM_WRITE     = 2'b11,
    parameter int         TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  memOp,
    output logic [31:0] addrB,
    output logic [31:0] dinB,
    input  logic [31:0] doutB,
    input  logic        bValid,
    input  logic        NOTready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic               r_store, w_store;
    logic [2:0]         r_funct3, w_funct3;
    logic [1:0]         r_addr_lo, w_addr_lo;
    logic [31:0]        r_wdata, w_wdata;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [1:0]         r_mem_op, w_mem_op;
    logic [31:0]        r_addr_b, w_addr_b;
    logic [31:0]        r_din_b, w_din_b;
    logic               r_resp_valid, w_resp_valid;
    logic [31:0]        r_resp_rdata, w_resp_rdata;
    logic               r_resp_err, w_resp_err;
    logic               r_req_ready, w_req_ready;

    function automatic logic req_bad(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal;
        logic misal;
        if (st) begin
            illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == 3'b010) && (lo != 2'b00));
        return illegal || misal;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        b       = shifted[7:0];
        h       = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h00_0000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Only the addressed lane changes; every other bit is the word just read back.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lo);
        logic [4:0]  sh;
        logic [31:0] res;
        sh = {lo, 3'b000};
        case (f3)
            3'b000:  res = (word & ~(32'h0000_00FF << sh)) | ({24'h00_0000, wd[7:0]} << sh);
            3'b001:  res = lo[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state      = r_state;
        w_store      = r_store;
        w_funct3     = r_funct3;
        w_addr_lo    = r_addr_lo;
        w_wdata      = r_wdata;
        w_cnt        = r_cnt;
        w_addr_b     = r_addr_b;
        w_din_b      = r_din_b;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = r_resp_err;
        w_mem_op     = MEM_DISABLE;
        w_resp_valid = 1'b0;
        w_req_ready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_store   = req_store;
                    w_funct3  = req_funct3;
                    w_addr_lo = req_addr[1:0];
                    w_wdata   = req_wdata;
                    if (req_bad(req_store, req_funct3, req_addr[1:0])) begin
                        w_state      = S_RESP;
                        w_resp_err   = 1'b1;
                        w_resp_rdata = 32'h0000_0000;
                    end else begin
                        w_addr_b = {req_addr[31:2], 2'b00};
                        if (req_store && (req_funct3 == 3'b010)) begin
                            w_din_b = req_wdata;
                            w_state = S_WRITE;
                        end else begin
                            w_state = S_READ;
                        end
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_READ: begin
                if (!NOTready) begin
                    w_state = S_WAIT;
                    w_cnt   = {CNT_W{1'b0}};
                end else begin
                    w_state = S_READ;
                end
            end
            S_WAIT: begin
                if (bValid) begin
                    if (r_store) begin
                        w_din_b = store_merge(doutB, r_wdata, r_funct3, r_addr_lo);
                        w_state = S_WRITE;
                    end else begin
                        w_resp_rdata = load_extract(doutB, r_funct3, r_addr_lo);
                        w_resp_err   = 1'b0;
                        w_state      = S_RESP;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_resp_rdata = 32'h0000_0000;
                    w_resp_err   = 1'b1;
                    w_state      = S_RESP;
                end else begin
                    w_cnt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WRITE: begin
                if (!NOTready) begin
                    w_resp_rdata = 32'h0000_0000;
                    w_resp_err   = 1'b0;
                    w_state      = S_RESP;
                end else begin
                    w_state = S_WRITE;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        case (w_state)
            S_READ:  w_mem_op = w_funct3[2] ? MEM_READ_ZEXT : MEM_READ_SEXT;
            S_WRITE: w_mem_op = MEM_WRITE;
            default: w_mem_op = MEM_DISABLE;
        endcase
        w_resp_valid = (w_state == S_RESP);
        w_req_ready  = (w_state == S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= 32'h0000_0000;
            r_cnt        <= {CNT_W{1'b0}};
            r_mem_op     <= MEM_DISABLE;
            r_addr_b     <= 32'h0000_0000;
            r_din_b      <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_store      <= w_store;
            r_funct3     <= w_funct3;
            r_addr_lo    <= w_addr_lo;
            r_wdata      <= w_wdata;
            r_cnt        <= w_cnt;
            r_mem_op     <= w_mem_op;
            r_addr_b     <= w_addr_b;
            r_din_b      <= w_din_b;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_req_ready  <= w_req_ready;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign memOp      = r_mem_op;
    assign addrB      = r_addr_b;
    assign dinB       = r_din_b;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the core's execute stage and the data port (port B) of the shared instruction/data RAM. Accepts one load or store request at a time and produces RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics on a word-only memory port. Byte and halfword stores use read-modify-write, and loads are extracted and sign- or zero-extended. A misaligned or illegal access, or a read timeout, returns an error response instead of data.

## Interface
Parameters:
- MEM_DISABLE, 2'b00, memOp code: idle
- MEM_READ_SEXT, 2'b01, memOp code: read (used for signed loads)
- MEM_READ_ZEXT, 2'b10, memOp code: read (used for LBU/LHU)
- MEM_WRITE, 2'b11, memOp code: full-word write
- TIMEOUT, 16, max WAIT cycles without bValid before error

Ports:
- clk  in  1  clock; everything is on posedge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  misaligned, illegal funct3, or timeout
- memOp  out  2  to memory
- addrB  out  32  word address {addr[31:2],2'b00}
- dinB  out  32  write word
- doutB  in  32  read word, registered in memory
- bValid  in  1  doutB valid
- NOTready  in  1  memory busy; hold current op

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1, memOp=MEM_DISABLE. When req_valid is high, latch the request and pick the next state:
  - illegal (load 011/110/111; store funct3 not 000/001/010) -> RESP with err.
  - misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) -> RESP with err.
  - SW -> WRITE with dinB=wdata.
  - all others -> READ.
- READ: memOp=MEM_READ_ZEXT for BU/HU, else MEM_READ_SEXT; addrB driven. If NOTready=1, stay in READ. Otherwise go to WAIT and clear the timeout counter.
- WAIT: memOp=MEM_DISABLE.
  - bValid=1 and load -> extract and extend into resp_rdata, go to RESP.
  - bValid=1 and SB/SH -> merge into dinB, go to WRITE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT -> RESP with err.
- WRITE: memOp=MEM_WRITE, addrB, dinB. If NOTready=1, stay in WRITE. Otherwise go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold their values until the next response.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k=addr[1:0]. The halfword uses lane addr[1].
- Merge: SB replaces only lane k with wdata[7:0]. SH replaces only lane addr[1] with wdata[15:0]. All other bits come from doutB.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Error responses never issue a memory write.

## Timing
- Reset (reset=0 at edge):
  - state=IDLE; memOp=MEM_DISABLE.
  - addrB, dinB, resp_rdata = 0; resp_valid=0; resp_err=0.
  - req_ready=0 while reset is held, 1 in the first cycle after release.
- Reset mid-operation abandons the request. No write or response follows, even if bValid arrives later.
- Cycle 0 is the cycle in which the request is accepted (edge at its end). With NOTready=0:
  - loads: READ c1, WAIT c2, resp_valid c3.
  - SW: WRITE c1, resp_valid c2.
  - SB/SH: READ c1, WAIT c2, WRITE c3, resp_valid c4.
  - error in IDLE: resp_valid c1, with no memOp activity.
- Each NOTready stall cycle in READ or WRITE adds one cycle.
- A timeout response appears TIMEOUT+1 cycles after entering WAIT.
- The next request can be accepted in the cycle after resp_valid.
- bValid seen in any state other than WAIT is ignored.

## Test plan
- Preload word 0x20=0x80FF7F01, then LB 0x23 -> resp_rdata=0xFFFFFF80. LBU 0x23 -> 0x00000080. Both have resp_valid at c3 and err=0.
- LH 0x22 -> 0xFFFF80FF. LHU 0x20 -> 0x00007F01. LW 0x20 -> 0x80FF7F01.
- SB addr 0x21, wdata 0x123456AB -> the single MEM_WRITE carries dinB=0x80FFAB01 at c3. A following LW 0x20 reads 0x80FFAB01.
- SW 0x24, wdata 0xDEADBEEF -> MEM_WRITE at c1, resp_valid at c2. Then SH 0x26, wdata 0x1234 -> dinB=0x1234BEEF.
- LW 0x22 and store funct3=100 -> resp_err=1 at c1, memOp stays MEM_DISABLE throughout.
- Memory model holds bValid=0 on LW -> resp_err=1 after TIMEOUT+1 WAIT cycles. NOTready=1 for 3 cycles during SW -> WRITE is held and resp_valid arrives at c5. Reset asserted in WAIT -> no write and no resp_valid.
